// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch-flush squash
// and a saturating count of the load-use bubbles inserted.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [3:0]        id_funct,
  input  logic              id_Branch,
  input  logic              id_MemRead,
  input  logic              id_MemtoReg,
  input  logic              id_MemWrite,
  input  logic              id_ALUSrc,
  input  logic              id_RegWrite,
  input  logic [1:0]        id_ALUOp,
  input  logic              ex_flush,
  output logic              stall_if_id,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [3:0]        ex_funct,
  output logic              ex_Branch,
  output logic              ex_MemRead,
  output logic              ex_MemtoReg,
  output logic              ex_MemWrite,
  output logic              ex_ALUSrc,
  output logic              ex_RegWrite,
  output logic [1:0]        ex_ALUOp,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    return (&v) ? v : v + one;
  endfunction

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [REG_AW-1:0] rs1_q, rs1_d;
  logic [REG_AW-1:0] rs2_q, rs2_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [3:0]        funct_q, funct_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic use_rs1, use_rs2, hazard, capture;

  // Every operand-use term is gated by id_valid, so garbage on id_* while
  // ID is empty can never raise a stall.
  always_comb begin
    use_rs1 = id_valid;
    use_rs2 = id_valid & (~id_ALUSrc | id_MemWrite);
    hazard  = valid_q & ctrl_q.mem_read & (rd_q != '0) &
              ((use_rs1 & (rd_q == id_rs1)) | (use_rs2 & (rd_q == id_rs2)));
    stall_if_id = hazard & ~ex_flush;
    capture     = id_valid & ~ex_flush & ~hazard;
  end

  always_comb begin
    valid_d    = 1'b0;
    pc_d       = '0;
    rs1_data_d = '0;
    rs2_data_d = '0;
    imm_d      = '0;
    rs1_d      = '0;
    rs2_d      = '0;
    rd_d       = '0;
    funct_d    = '0;
    ctrl_d     = '0;
    cnt_d      = cnt_q;
    if (~ex_flush & hazard) begin
      cnt_d = sat_inc(cnt_q);
    end
    if (capture) begin
      valid_d    = 1'b1;
      pc_d       = id_pc;
      rs1_data_d = id_rs1_data;
      rs2_data_d = id_rs2_data;
      imm_d      = id_imm;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      rd_d       = id_rd;
      funct_d    = id_funct;
      ctrl_d     = '{branch:     id_Branch,
                     mem_read:   id_MemRead,
                     mem_to_reg: id_MemtoReg,
                     mem_write:  id_MemWrite,
                     alu_src:    id_ALUSrc,
                     reg_write:  id_RegWrite,
                     alu_op:     id_ALUOp};
    end
  end

  // ID -> EX register boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      funct_q    <= '0;
      ctrl_q     <= '0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      funct_q    <= funct_d;
      ctrl_q     <= ctrl_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_pc       = pc_q;
  assign ex_rs1_data = rs1_data_q;
  assign ex_rs2_data = rs2_data_q;
  assign ex_imm      = imm_q;
  assign ex_rs1      = rs1_q;
  assign ex_rs2      = rs2_q;
  assign ex_rd       = rd_q;
  assign ex_funct    = funct_q;
  assign ex_Branch   = ctrl_q.branch;
  assign ex_MemRead  = ctrl_q.mem_read;
  assign ex_MemtoReg = ctrl_q.mem_to_reg;
  assign ex_MemWrite = ctrl_q.mem_write;
  assign ex_ALUSrc   = ctrl_q.alu_src;
  assign ex_RegWrite = ctrl_q.reg_write;
  assign ex_ALUOp    = ctrl_q.alu_op;
  assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, saturation sequence and a
// randomized phase checked against a rule-level reference model.
module tb_id_ex_stage;
  localparam int XL   = 32;
  localparam int AW   = 5;
  localparam int CW   = 4;  // narrow counter so saturation is reachable quickly
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic          rst;
    logic          flush;
    logic          valid;
    logic [XL-1:0] pc, rs1d, rs2d, imm;
    logic [AW-1:0] rs1, rs2, rd;
    logic [3:0]    funct;
    logic          br, mr, m2r, mw, alusrc, rw;
    logic [1:0]    aluop;
  } in_t;

  typedef struct packed {
    logic          valid;
    logic [XL-1:0] pc, rs1d, rs2d, imm;
    logic [AW-1:0] rs1, rs2, rd;
    logic [3:0]    funct;
    logic          br, mr, m2r, mw, alusrc, rw;
    logic [1:0]    aluop;
  } ex_t;

  typedef struct {
    in_t           in;
    bit            cs;
    logic          es, ev;
    logic [AW-1:0] erd, ers1;
    logic          emr, erw;
    logic [CW-1:0] ecnt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, id_valid, ex_flush;
  logic [XL-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic [3:0]    id_funct;
  logic          id_Branch, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite;
  logic [1:0]    id_ALUOp;
  logic          stall_if_id, ex_valid;
  logic [XL-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [3:0]    ex_funct;
  logic          ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite;
  logic [1:0]    ex_ALUOp;
  logic [CW-1:0] stall_cnt;

  id_ex_stage #(.XLEN(XL), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
    .id_Branch(id_Branch), .id_MemRead(id_MemRead), .id_MemtoReg(id_MemtoReg),
    .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc), .id_RegWrite(id_RegWrite),
    .id_ALUOp(id_ALUOp), .ex_flush(ex_flush), .stall_if_id(stall_if_id),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_funct(ex_funct), .ex_Branch(ex_Branch),
    .ex_MemRead(ex_MemRead), .ex_MemtoReg(ex_MemtoReg), .ex_MemWrite(ex_MemWrite),
    .ex_ALUSrc(ex_ALUSrc), .ex_RegWrite(ex_RegWrite), .ex_ALUOp(ex_ALUOp),
    .stall_cnt(stall_cnt)
  );

  int  n_chk  = 0;
  int  n_fail = 0;
  int  step   = 0;
  ex_t m_ex;
  int  m_cnt;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h want %0h", name, step, got, exp);
    end
  endtask

  // ---- instruction builders ----
  function automatic in_t i_base();
    in_t t;
    t = '0;
    t.pc = $urandom; t.rs1d = $urandom; t.rs2d = $urandom; t.imm = $urandom;
    return t;
  endfunction

  function automatic in_t i_rand(input logic r);
    in_t t;
    t = i_base();
    {t.valid, t.br, t.mr, t.m2r, t.mw, t.alusrc, t.rw, t.aluop} = 9'($urandom);
    t.rs1 = AW'($urandom); t.rs2 = AW'($urandom); t.rd = AW'($urandom);
    t.funct = 4'($urandom);
    t.rst = r;
    return t;
  endfunction

  function automatic in_t i_r(input logic [AW-1:0] rd, rs1, rs2, input logic [XL-1:0] pc);
    in_t t;
    t = i_base();
    t.valid = 1'b1; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.pc = pc;
    t.rw = 1'b1; t.aluop = 2'b10;
    return t;
  endfunction

  function automatic in_t i_ld(input logic [AW-1:0] rd, rs1);
    in_t t;
    t = i_base();
    t.valid = 1'b1; t.rd = rd; t.rs1 = rs1; t.funct = 4'b0010;
    t.mr = 1'b1; t.m2r = 1'b1; t.alusrc = 1'b1; t.rw = 1'b1;
    return t;
  endfunction

  function automatic in_t i_addi(input logic [AW-1:0] rd, rs1, rs2f);
    in_t t;
    t = i_base();
    t.valid = 1'b1; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2f;
    t.alusrc = 1'b1; t.rw = 1'b1; t.aluop = 2'b10;
    return t;
  endfunction

  function automatic in_t i_sw(input logic [AW-1:0] rs1, rs2, immlo);
    in_t t;
    t = i_base();
    t.valid = 1'b1; t.rs1 = rs1; t.rs2 = rs2; t.rd = immlo; t.funct = 4'b0010;
    t.mw = 1'b1; t.alusrc = 1'b1;
    return t;
  endfunction

  function automatic in_t i_garbage();
    in_t t;
    t = i_rand(1'b0);
    t.valid = 1'b0;
    {t.br, t.mr, t.m2r, t.mw, t.alusrc, t.rw, t.aluop} = 8'hFF;
    return t;
  endfunction

  // ---- reference model ----
  function automatic bit m_haz(input ex_t e, input in_t i);
    bit u1, u2;
    u1 = i.valid;
    u2 = i.valid && (!i.alusrc || i.mw);
    return e.valid && e.mr && (e.rd != 0) &&
           ((u1 && e.rd == i.rs1) || (u2 && e.rd == i.rs2));
  endfunction

  task automatic m_step(input in_t i);
    bit h;
    h = m_haz(m_ex, i);
    if (i.rst) begin
      m_ex = '0; m_cnt = 0;
    end else if (i.flush) begin
      m_ex = '0;
    end else if (h) begin
      m_ex = '0;
      m_cnt = (m_cnt >= CMAX) ? CMAX : m_cnt + 1;
    end else if (i.valid) begin
      m_ex = '{valid: 1'b1, pc: i.pc, rs1d: i.rs1d, rs2d: i.rs2d, imm: i.imm,
               rs1: i.rs1, rs2: i.rs2, rd: i.rd, funct: i.funct, br: i.br, mr: i.mr,
               m2r: i.m2r, mw: i.mw, alusrc: i.alusrc, rw: i.rw, aluop: i.aluop};
    end else begin
      m_ex = '0;
    end
  endtask

  function automatic ex_t dut_ex();
    return '{valid: ex_valid, pc: ex_pc, rs1d: ex_rs1_data, rs2d: ex_rs2_data,
             imm: ex_imm, rs1: ex_rs1, rs2: ex_rs2, rd: ex_rd, funct: ex_funct,
             br: ex_Branch, mr: ex_MemRead, m2r: ex_MemtoReg, mw: ex_MemWrite,
             alusrc: ex_ALUSrc, rw: ex_RegWrite, aluop: ex_ALUOp};
  endfunction

  task automatic drive(input in_t v);
    rst = v.rst; ex_flush = v.flush; id_valid = v.valid;
    id_pc = v.pc; id_rs1_data = v.rs1d; id_rs2_data = v.rs2d; id_imm = v.imm;
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd; id_funct = v.funct;
    id_Branch = v.br; id_MemRead = v.mr; id_MemtoReg = v.m2r; id_MemWrite = v.mw;
    id_ALUSrc = v.alusrc; id_RegWrite = v.rw; id_ALUOp = v.aluop;
  endtask

  // Drive on the falling edge, check the combinational stall, clock, then check EX.
  task automatic apply(input in_t v, input bit chk_stall);
    @(negedge clk);
    drive(v);
    #1;
    if (chk_stall) chk("stall_model", 256'(stall_if_id), 256'(m_haz(m_ex, v) && !v.flush));
    @(posedge clk);
    m_step(v);
    #1;
    chk("ex_bundle", 256'(dut_ex()), 256'(m_ex));
    chk("stall_cnt_model", 256'(stall_cnt), 256'(m_cnt));
    step++;
  endtask

  function automatic vec_t mkv(input in_t i, input bit cs, input logic es, ev,
                               input logic [AW-1:0] erd, ers1, input logic emr, erw,
                               input logic [CW-1:0] ecnt);
    vec_t v;
    v.in = i; v.cs = cs; v.es = es; v.ev = ev; v.erd = erd; v.ers1 = ers1;
    v.emr = emr; v.erw = erw; v.ecnt = ecnt;
    return v;
  endfunction

  vec_t tbl[22];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t t;
    m_ex = '0; m_cnt = 0;
    drive(i_rand(1'b1));

    tbl[0]  = mkv(i_rand(1'b1),      0, 0, 0, 0,  0, 0, 0, 0);
    tbl[1]  = mkv(i_rand(1'b1),      1, 0, 0, 0,  0, 0, 0, 0);
    tbl[2]  = mkv(i_r(5, 1, 2, 32'h100), 1, 0, 1, 5, 1, 0, 1, 0);
    tbl[3]  = mkv(i_ld(6, 1),        1, 0, 1, 6,  1, 1, 1, 0);
    tbl[4]  = mkv(i_r(7, 6, 3, 32'h108), 1, 1, 0, 0, 0, 0, 0, 1);
    tbl[5]  = mkv(i_r(7, 6, 3, 32'h108), 1, 0, 1, 7, 6, 0, 1, 1);
    tbl[6]  = mkv(i_ld(0, 2),        1, 0, 1, 0,  2, 1, 1, 1);
    tbl[7]  = mkv(i_r(9, 0, 0, 32'h110), 1, 0, 1, 9, 0, 0, 1, 1);
    tbl[8]  = mkv(i_ld(6, 1),        1, 0, 1, 6,  1, 1, 1, 1);
    tbl[9]  = mkv(i_addi(8, 9, 6),   1, 0, 1, 8,  9, 0, 1, 1);
    tbl[10] = mkv(i_ld(6, 1),        1, 0, 1, 6,  1, 1, 1, 1);
    tbl[11] = mkv(i_sw(2, 6, 3),     1, 1, 0, 0,  0, 0, 0, 2);
    tbl[12] = mkv(i_sw(2, 6, 3),     1, 0, 1, 3,  2, 0, 0, 2);
    tbl[13] = mkv(i_ld(6, 1),        1, 0, 1, 6,  1, 1, 1, 2);
    t = i_r(7, 6, 3, 32'h120); t.flush = 1'b1;
    tbl[14] = mkv(t,                 1, 0, 0, 0,  0, 0, 0, 2);
    tbl[15] = mkv(i_r(7, 6, 3, 32'h124), 1, 0, 1, 7, 6, 0, 1, 2);
    tbl[16] = mkv(i_ld(6, 1),        1, 0, 1, 6,  1, 1, 1, 2);
    tbl[17] = mkv(i_ld(10, 6),       1, 1, 0, 0,  0, 0, 0, 3);
    tbl[18] = mkv(i_ld(10, 6),       1, 0, 1, 10, 6, 1, 1, 3);
    t = i_r(11, 10, 0, 32'h130); t.rst = 1'b1;
    tbl[19] = mkv(t,                 1, 1, 0, 0,  0, 0, 0, 0);
    tbl[20] = mkv(i_r(11, 10, 0, 32'h130), 1, 0, 1, 11, 10, 0, 1, 0);
    tbl[21] = mkv(i_garbage(),       1, 0, 0, 0,  0, 0, 0, 0);

    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      drive(tbl[k].in);
      #1;
      if (tbl[k].cs) chk("stall_if_id", 256'(stall_if_id), 256'(tbl[k].es));
      @(posedge clk);
      m_step(tbl[k].in);
      #1;
      chk("ex_valid", 256'(ex_valid), 256'(tbl[k].ev));
      chk("ex_rd", 256'(ex_rd), 256'(tbl[k].erd));
      chk("ex_rs1", 256'(ex_rs1), 256'(tbl[k].ers1));
      chk("ex_MemRead", 256'(ex_MemRead), 256'(tbl[k].emr));
      chk("ex_RegWrite", 256'(ex_RegWrite), 256'(tbl[k].erw));
      chk("stall_cnt", 256'(stall_cnt), 256'(tbl[k].ecnt));
      chk("ex_bundle", 256'(dut_ex()), 256'(m_ex));
      step++;
    end

    // Drive the counter to CMAX-1, then three more stalls must all read CMAX.
    for (int k = 1; k <= CMAX + 2; k++) begin
      apply(i_ld(6, 1), 1'b1);
      apply(i_r(7, 6, 3, 32'h200), 1'b1);
      chk("sat_bubble", 256'(ex_valid), 256'(0));
      chk("sat_cnt", 256'(stall_cnt), 256'((k < CMAX) ? k : CMAX));
      apply(i_r(7, 6, 3, 32'h200), 1'b1);
      chk("sat_consumer_rs1", 256'(ex_rs1), 256'(6));
    end

    for (int k = 0; k < 300; k++) begin
      t = i_rand(($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0);
      t.valid = ($urandom_range(0, 3) != 0);
      t.rs1 = AW'($urandom_range(0, 3));
      t.rs2 = AW'($urandom_range(0, 3));
      t.rd  = AW'($urandom_range(0, 3));
      t.flush = ($urandom_range(0, 7) == 0);
      apply(t, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
